// File: rtl/aud_sram_arb_if.sv
// Bundle of all arbiter signals: core request/return, host handshake and the
// SRAM macro port.
//   slave  : arbiter view (consumes requests and read data, drives the macro)
//   master : environment view (requesters plus macro model)
interface aud_sram_arb_if #(
  parameter int unsigned DW = 22,
  parameter int unsigned AW = 10
);
  localparam int unsigned WW = 2 * DW;

  // core (requester 0)
  logic [AW-1:0] addr_0;
  logic          en_0;
  logic          we_0;
  logic [7:0]    wbe_0;
  logic [WW-1:0] wdata_0;
  logic [WW-1:0] rdata_0;
  logic          stall_0;

  // host (requester 1)
  logic [AW-1:0] addr_1;
  logic          en_1;
  logic          rdy_1;
  logic          we_1;
  logic [7:0]    wbe_1;
  logic [WW-1:0] wdata_1;
  logic [WW-1:0] rdata_1;
  logic          rdata_1_vld;
  logic          force_gnt;

  // SRAM macro
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_we;
  logic [7:0]    sram_wbe;
  logic [WW-1:0] sram_wdata;
  logic [WW-1:0] sram_rdata;

  modport slave (
    input  addr_0, en_0, we_0, wbe_0, wdata_0,
    output rdata_0, stall_0,
    input  addr_1, en_1, we_1, wbe_1, wdata_1,
    output rdy_1, rdata_1, rdata_1_vld, force_gnt,
    output sram_addr, sram_en, sram_we, sram_wbe, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output addr_0, en_0, we_0, wbe_0, wdata_0,
    input  rdata_0, stall_0,
    output addr_1, en_1, we_1, wbe_1, wdata_1,
    input  rdy_1, rdata_1, rdata_1_vld, force_gnt,
    input  sram_addr, sram_en, sram_we, sram_wbe, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/aud_sram_arb.sv
// Two-requester single-port SRAM arbiter for the audio DSP buffers.
// The core (requester 0) has fixed priority; the host (requester 1) is
// force-granted after STARVE_MAX consecutive blocked cycles, stalling the
// core for that single cycle. Grant and SRAM drive are combinational; read
// data returns one cycle after the grant.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aud_sram_arb_if.slave (core, host and SRAM macro signals)
module aud_sram_arb #(
  parameter int unsigned DW         = 22,
  parameter int unsigned AW         = 10,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input logic            clk,
  input logic            rst_n,
  aud_sram_arb_if.slave  bus
);

  localparam int unsigned WW = 2 * DW;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             gnt0;
  logic             gnt1;
  logic             rd0_q;
  logic             rd1_q;
  logic [WW-1:0]    rdata_1_q;

  // Grant: host wins only when the core is idle or the host is starved.
  always_comb begin
    starved = (starve_cnt == CNT_W'(STARVE_MAX));
    gnt1    = bus.en_1 && (!bus.en_0 || starved);
    gnt0    = bus.en_0 && !gnt1;
  end

  // Handshake outputs and SRAM mux; idle cycles drive the macro with zeros.
  always_comb begin
    bus.rdy_1      = gnt1;
    bus.stall_0    = bus.en_0 && gnt1;
    bus.force_gnt  = gnt1 && bus.en_0;
    bus.sram_en    = gnt0 | gnt1;
    bus.sram_addr  = '0;
    bus.sram_we    = 1'b0;
    bus.sram_wbe   = '0;
    bus.sram_wdata = '0;
    if (gnt1) begin
      bus.sram_addr  = bus.addr_1;
      bus.sram_we    = bus.we_1;
      bus.sram_wbe   = bus.wbe_1;
      bus.sram_wdata = bus.wdata_1;
    end else if (gnt0) begin
      bus.sram_addr  = bus.addr_0;
      bus.sram_we    = bus.we_0;
      bus.sram_wbe   = bus.wbe_0;
      bus.sram_wdata = bus.wdata_0;
    end
  end

  // Starvation counter: counts cycles the host is blocked by the core and
  // restarts after every host grant or withdrawal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (gnt1 || !bus.en_1) begin
      starve_cnt <= '0;
    end else if (bus.en_0 && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Read-return tracking for the one-cycle macro latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_q     <= 1'b0;
      rd1_q     <= 1'b0;
      rdata_1_q <= '0;
    end else begin
      rd0_q <= gnt0 && !bus.we_0;
      rd1_q <= gnt1 && !bus.we_1;
      if (rd1_q) begin
        rdata_1_q <= bus.sram_rdata;
      end
    end
  end

  // Host data is presented live on the return cycle and held afterwards.
  always_comb begin
    bus.rdata_0     = rd0_q ? bus.sram_rdata : '0;
    bus.rdata_1_vld = rd1_q;
    bus.rdata_1     = rd1_q ? bus.sram_rdata : rdata_1_q;
  end

endmodule

// File: doc/aud_sram_arb.md
Name: aud_sram_arb

Overview:
Two-requester, single-port SRAM arbiter for the audio DSP buffers (sample buffer, buffer A/B, coefficient table).
- Requester 0 is the processing core. It is latency-critical and has fixed priority.
- Requester 1 is the host bus. It uses a valid/ready handshake.
- A starvation counter force-grants the host after a bounded wait, stalling the core for that cycle.
- Sits between the bus-mux address decode and each SRAM macro; one instance per SRAM.

Parameters:
DW, 22, half-word data width; the SRAM word is 2*DW.
AW, 10, SRAM word-address width.
STARVE_MAX, 8, consecutive host-blocked cycles before a forced host grant (1..2**CNT_W-1).
CNT_W, 4, starvation counter width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
addr_0  in  AW  core word address
en_0  in  1  core access request
we_0  in  1  core write (1) / read (0)
wbe_0  in  8  core byte enables; [3:0] low half, [7:4] high half
wdata_0  in  2*DW  core write data
rdata_0  out  2*DW  core read data, valid the cycle after the core grant
stall_0  out  1  core request not accepted this cycle; core holds all req_0 signals
addr_1  in  AW  host word address
en_1  in  1  host request valid
rdy_1  out  1  host request accepted this cycle
we_1  in  1  host write / read
wbe_1  in  8  host byte enables
wdata_1  in  2*DW  host write data
rdata_1  out  2*DW  host read data
rdata_1_vld  out  1  one-cycle pulse: rdata_1 valid
force_gnt  out  1  current host grant was forced by starvation
sram_addr  out  AW  to macro
sram_en  out  1  to macro
sram_we  out  1  to macro
sram_wbe  out  8  to macro
sram_wdata  out  2*DW  to macro
sram_rdata  in  2*DW  macro read data, 1-cycle latency

Behaviour:
- Single clock clk; rst_n is asynchronous, active-low.
- Grant (combinational):
  - starved = (starve_cnt == STARVE_MAX)
  - gnt1 = en_1 && (!en_0 || starved)
  - gnt0 = en_0 && !gnt1
- Derived outputs:
  - rdy_1 = gnt1
  - stall_0 = en_0 && gnt1
  - force_gnt = gnt1 && en_0
- SRAM drive:
  - sram_en = gnt0 | gnt1.
  - addr/we/wbe/wdata are muxed from the granted requester.
  - With no grant, all SRAM outputs are driven 0; sram_we is never 1 while sram_en is 0.
- starve_cnt (CNT_W bits, reset 0):
  - Clears when gnt1, or when !en_1.
  - Otherwise, when en_1 && en_0, increments, saturating at STARVE_MAX.
  - After a forced grant the count restarts at 0. The host therefore gets at least 1 of every STARVE_MAX+1 cycles under continuous core traffic.
- Read return registers (reset 0):
  - rd0_q <= gnt0 && !we_0
  - rd1_q <= gnt1 && !we_1
- rdata_0 = sram_rdata when rd0_q, else 0.
- Host read data:
  - rdata_1_vld = rd1_q.
  - rdata_1 = rd1_q ? sram_rdata : rdata_1_q.
  - rdata_1_q captures sram_rdata when rd1_q; reset 0, holds between reads.
- Latency:
  - Host read: rdy_1 in cycle N → rdata_1_vld in N+1.
  - Host write: completes in the rdy_1 cycle; no vld pulse.
- Host back-to-back: a new request may be accepted in the same cycle as a vld pulse for the previous one.
- Simultaneous en_0 && en_1 with counter below STARVE_MAX: core wins, rdy_1=0.
- Core stall: the core must hold addr_0/we_0/wbe_0/wdata_0 while stall_0=1. Stall lasts exactly one cycle per forced grant.
- Host drops en_1 before being granted: counter clears; no SRAM access.
- Reset mid-operation:
  - All registers clear; rdata_1_vld and pending read tracking are dropped.
  - Reads in flight are lost; the requester re-issues.
- Reset values of outputs (with en_0=en_1=0): all 0.

Test Plan:
- Host only: en_1=1, we_1=0, addr_1=0x12, macro returns 0x0AB_CDEF_123 → rdy_1=1 cycle N, sram_addr=0x12, rdata_1_vld=1 and rdata_1=0x0AB_CDEF_123 in N+1, held after.
- Core continuous reads plus host request held, STARVE_MAX=8:
  - Cycles 0..7: rdy_1=0, stall_0=0.
  - Cycle 8: rdy_1=1, stall_0=1, force_gnt=1.
  - Cycles 9..16: core again.
- Same-cycle request, counter=0: en_0=en_1=1 → sram_addr=addr_0, rdy_1=0; the core read returns rdata_0 next cycle while rdata_1_vld stays 0.
- Host write: we_1=1, wbe_1=0xF0, wdata_1=0x155555_2AAAAA → sram_we=1, sram_wbe=0xF0, data passed unchanged; no rdata_1_vld pulse.
- Host withdraws at counter=5: en_1 dropped → counter=0. Re-assert with core busy → 8 further wait cycles before the forced grant.
- Reset asserted the cycle after a host read grant → rdata_1_vld=0, rdata_1=0, starve_cnt=0 immediately (asynchronous).
